rename_rat: RTL
===============

# rename_rat

Two-wide register-rename stage sitting directly upstream of `freelist_RAT`. Each cycle it accepts up to two decoded instructions, maps architectural sources through a speculative map table, and allocates new physical destinations by popping the free list. It also forwards committed old physical registers back to the free list. Renamed instructions leave through one registered output stage with a valid/ready handshake toward dispatch/ROB.

## Interface
- `AR_W`, 5, architectural register index width (32 arch regs)
- `PR_W`, 6, physical register tag width (64 PRs); must match free list
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `in_valid1`, `in_valid2` in 1 each: slot valid; `in_valid2` only meaningful with `in_valid1`
- `in_rs1_1`, `in_rs2_1`, `in_rd_1`, `in_rs1_2`, `in_rs2_2`, `in_rd_2` in AR_W: arch sources/dest per slot
- `in_we_1`, `in_we_2` in 1: slot writes rd
- `in_ready` out 1: group accepted this cycle when high with `in_valid1`
- `no_free_pr` in 1: free list empty
- `one_free_pr` in 1: free list holds exactly one entry
- `pop_data_fl_RAT1`, `pop_data_fl_RAT2` in PR_W: free-list head, head+1
- `pop_fl_RAT` out 2: pop count 0/1/2, combinational, consumed at same edge
- `out_valid` out 1; `out_ready` in 1: downstream handshake
- `out_v1`, `out_v2` out 1: slot valid in output group
- `out_ps1_1`, `out_ps2_1`, `out_pd_1`, `out_old_pd_1` (and `_2` variants) out PR_W
- `out_we_1`, `out_we_2` out 1: slot allocated a new PR
- `cm_valid1`, `cm_valid2` in 1; `cm_old_pd1`, `cm_old_pd2` in PR_W: commit releases
- `push_fl_RAT` out 2; `push_data_fl_RAT1`, `push_data_fl_RAT2` out PR_W: registered release to free list

## Operation
- Map table: 32 entries × PR_W. Reset: map[i] = i. x0 is never renamed; sources x0 read PR 0.
- Slot needs a PR when valid && we && rd≠0. n = number of needing slots (0–2).
- Free count f = 0 if `no_free_pr`, 1 if `one_free_pr`, else 2.
- out_free = !out_valid || out_ready. `in_ready` = out_free && n ≤ f (depends on current inputs, documented).
- fire = in_valid1 && in_ready. `pop_fl_RAT` = fire ? n : 0.
- Allocation in order: first needing slot takes `pop_data_fl_RAT1`, second takes `pop_data_fl_RAT2`.
- Slot1: ps = map[rs], old_pd = map[rd], pd = allocated or 0.
- Slot2 intra-group bypass: rs1/rs2/rd equal to slot1's renamed rd (we1, rd1≠0) use slot1's new pd, including old_pd.
- Map write on fire: slot1 then slot2; same rd → slot2's pd wins.
- Non-writing slot: out_we=0, pd=0, old_pd=0.
- Output register loads on fire; holds while out_valid && !out_ready; clears when consumed with no fire.
- Commit: push_fl_RAT = cm_valid1+cm_valid2, compacted. Lone cm_valid2 goes to data1. Registered one cycle, no backpressure.

## Timing
- Reset values: out_valid, out_v*, out_we* = 0; all PR outputs 0; push_fl_RAT = 0; map identity. `pop_fl_RAT` = 0 while reset is high.
- Rename latency: 1 cycle, fire at edge k → outputs valid after edge k.
- Full throughput: 2 instr/cycle when out_ready high and f ≥ n.
- Stall n > f: no pop, no map write, no partial group acceptance.
- Commit→push latency 1 cycle; simultaneous pop and push permitted.
- Reset mid-operation: in-flight output and pending push are discarded; map returns to identity.

## Test plan
- Reset, slot1 add x3,x1,x2, free head 32 → pop=01; next cycle ps1=1, ps2=2, pd=32, old_pd=3, out_we_1=1.
- Slots rd=x5 / rs1=x5,rd=x5, heads 40,41 → pop=10; slot2 ps1=40, old_pd=40, pd=41; later read of x5 gives 41.
- one_free_pr=1 with n=2 → in_ready=0, pop=00, map unchanged; same cycle with n=1 → accepted, pop=01.
- out_ready=0 with out_valid=1 → outputs stable, in_ready=0, pop=00 for 3 cycles; release → next group loads.
- cm_valid2 only, old 7 → next cycle push_fl_RAT=01, push_data_fl_RAT1=7; both valid 9,11 → push=10, data 9/11.
- rd=x0 with we=1 → pop=00, out_we=0, pd=0; reset asserted mid-stream → out_valid=0 next cycle, map identity.

Source files
------------

// File: rtl/rename_rat.sv
// Two-wide register rename stage: speculative map table, free-list allocation,
// one registered output group toward dispatch and a registered commit-release path.
module rename_rat #(
  parameter int unsigned AR_W = 5,
  parameter int unsigned PR_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  // Decode side
  input  logic            in_valid1,
  input  logic            in_valid2,
  input  logic [AR_W-1:0] in_rs1_1,
  input  logic [AR_W-1:0] in_rs2_1,
  input  logic [AR_W-1:0] in_rd_1,
  input  logic [AR_W-1:0] in_rs1_2,
  input  logic [AR_W-1:0] in_rs2_2,
  input  logic [AR_W-1:0] in_rd_2,
  input  logic            in_we_1,
  input  logic            in_we_2,
  output logic            in_ready,
  // Free list pop side
  input  logic            no_free_pr,
  input  logic            one_free_pr,
  input  logic [PR_W-1:0] pop_data_fl_RAT1,
  input  logic [PR_W-1:0] pop_data_fl_RAT2,
  output logic [1:0]      pop_fl_RAT,
  // Dispatch side
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_v1,
  output logic            out_v2,
  output logic [PR_W-1:0] out_ps1_1,
  output logic [PR_W-1:0] out_ps2_1,
  output logic [PR_W-1:0] out_pd_1,
  output logic [PR_W-1:0] out_old_pd_1,
  output logic [PR_W-1:0] out_ps1_2,
  output logic [PR_W-1:0] out_ps2_2,
  output logic [PR_W-1:0] out_pd_2,
  output logic [PR_W-1:0] out_old_pd_2,
  output logic            out_we_1,
  output logic            out_we_2,
  // Commit release side
  input  logic            cm_valid1,
  input  logic            cm_valid2,
  input  logic [PR_W-1:0] cm_old_pd1,
  input  logic [PR_W-1:0] cm_old_pd2,
  output logic [1:0]      push_fl_RAT,
  output logic [PR_W-1:0] push_data_fl_RAT1,
  output logic [PR_W-1:0] push_data_fl_RAT2
);

  localparam int unsigned NumAr = 2 ** AR_W;

  typedef struct packed {
    logic            valid;
    logic            v1;
    logic            v2;
    logic            we1;
    logic            we2;
    logic [PR_W-1:0] ps1_1;
    logic [PR_W-1:0] ps2_1;
    logic [PR_W-1:0] pd_1;
    logic [PR_W-1:0] old_pd_1;
    logic [PR_W-1:0] ps1_2;
    logic [PR_W-1:0] ps2_2;
    logic [PR_W-1:0] pd_2;
    logic [PR_W-1:0] old_pd_2;
  } out_t;

  logic [PR_W-1:0] map_q [NumAr];
  logic [PR_W-1:0] map_d [NumAr];
  out_t            out_q, out_d;
  logic [1:0]      push_q, push_d;
  logic [PR_W-1:0] push1_q, push1_d, push2_q, push2_d;

  logic            need1, need2, fire;
  logic [1:0]      n_need, n_free;
  logic [PR_W-1:0] pd1, pd2;

  // Allocation demand, handshake and new-tag selection
  always_comb begin
    need1    = in_valid1 && in_we_1 && (in_rd_1 != '0);
    need2    = in_valid1 && in_valid2 && in_we_2 && (in_rd_2 != '0);
    n_need   = {1'b0, need1} + {1'b0, need2};
    n_free   = no_free_pr ? 2'd0 : (one_free_pr ? 2'd1 : 2'd2);
    in_ready = (!out_q.valid || out_ready) && (n_need <= n_free);
    fire     = in_valid1 && in_ready && !reset;
    pop_fl_RAT = fire ? n_need : 2'd0;
    pd1 = need1 ? pop_data_fl_RAT1 : '0;
    // Slot 2 takes head+1 only when slot 1 already consumed the head
    pd2 = need2 ? (need1 ? pop_data_fl_RAT2 : pop_data_fl_RAT1) : '0;
  end

  // Rename lookup with slot-1 to slot-2 bypass, map update and output register next state
  always_comb begin
    map_d = map_q;
    out_d = out_q;
    if (fire) begin
      out_d.valid    = 1'b1;
      out_d.v1       = 1'b1;
      out_d.v2       = in_valid2;
      out_d.we1      = need1;
      out_d.we2      = need2;
      out_d.ps1_1    = map_q[in_rs1_1];
      out_d.ps2_1    = map_q[in_rs2_1];
      out_d.pd_1     = pd1;
      out_d.old_pd_1 = need1 ? map_q[in_rd_1] : '0;
      // need1 implies rd1 != 0, so x0 sources never hit the bypass
      out_d.ps1_2    = (need1 && in_rs1_2 == in_rd_1) ? pd1 : map_q[in_rs1_2];
      out_d.ps2_2    = (need1 && in_rs2_2 == in_rd_1) ? pd1 : map_q[in_rs2_2];
      out_d.pd_2     = pd2;
      out_d.old_pd_2 = need2 ? ((need1 && in_rd_2 == in_rd_1) ? pd1 : map_q[in_rd_2]) : '0;
      if (need1) map_d[in_rd_1] = pd1;
      if (need2) map_d[in_rd_2] = pd2;  // later write wins on same rd
    end else if (out_ready) begin
      out_d = '0;
    end
  end

  // Commit releases compacted so a lone slot-2 release lands in data1
  always_comb begin
    push_d  = {1'b0, cm_valid1} + {1'b0, cm_valid2};
    push1_d = cm_valid1 ? cm_old_pd1 : (cm_valid2 ? cm_old_pd2 : '0);
    push2_d = (cm_valid1 && cm_valid2) ? cm_old_pd2 : '0;
  end

  // State registers with synchronous reset; map returns to identity
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumAr; i++) map_q[i] <= PR_W'(i);
      out_q   <= '0;
      push_q  <= '0;
      push1_q <= '0;
      push2_q <= '0;
    end else begin
      map_q   <= map_d;
      out_q   <= out_d;
      push_q  <= push_d;
      push1_q <= push1_d;
      push2_q <= push2_d;
    end
  end

  assign out_valid         = out_q.valid;
  assign out_v1            = out_q.v1;
  assign out_v2            = out_q.v2;
  assign out_we_1          = out_q.we1;
  assign out_we_2          = out_q.we2;
  assign out_ps1_1         = out_q.ps1_1;
  assign out_ps2_1         = out_q.ps2_1;
  assign out_pd_1          = out_q.pd_1;
  assign out_old_pd_1      = out_q.old_pd_1;
  assign out_ps1_2         = out_q.ps1_2;
  assign out_ps2_2         = out_q.ps2_2;
  assign out_pd_2          = out_q.pd_2;
  assign out_old_pd_2      = out_q.old_pd_2;
  assign push_fl_RAT       = push_q;
  assign push_data_fl_RAT1 = push1_q;
  assign push_data_fl_RAT2 = push2_q;

endmodule
